aes_dec_sched: RTL and testbench
================================

AES_DEC_SCHED -- requirements
Module: aes_dec_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, output-buffer depth and maximum outstanding blocks (power of 2, ≥2).
REQ-002 SHALL have parameter KEYEXP_CYCLES, default 11, cycles the core's key-expansion FSM needs after the fsm_en pulse.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key  input  128  new cipher key, sampled when key_load=1.
REQ-006 SHALL have port key_load  input  1  single-cycle key-change request.
REQ-007 SHALL have port key_busy  output  1  high in every state except RUN.
REQ-008 SHALL have ports s_valid input 1, s_ready output 1 and s_data input 128 for the ciphertext-in valid/ready handshake.
REQ-009 SHALL have ports m_valid output 1, m_ready input 1 and m_data output 128 for the plaintext-out valid/ready handshake.
REQ-010 SHALL have ports core_in output 128, core_key output 128, core_enable output 1 and core_fsm_en output 1, all driving the AES_dec core.
REQ-011 SHALL have ports core_out input 128 and core_valid_out input 1, both from the AES_dec core.
REQ-012 SHALL have port err_ovf  output  1  sticky flag set when a result arrives while the FIFO is full.

Function
REQ-013 SHALL implement states IDLE, KEY_EXP, RUN and DRAIN, entering IDLE from reset.
REQ-014 SHALL, in any state, capture key into a key register on key_load, and SHALL drive core_key from that register at all times.
REQ-015 SHALL go from IDLE to KEY_EXP on key_load.
REQ-016 SHALL, on entry to KEY_EXP, assert core_fsm_en for exactly one cycle, then count KEYEXP_CYCLES cycles, then go to RUN.
REQ-017 SHALL, on a key_load in KEY_EXP, restart the pulse and the count using the new key.
REQ-018 SHALL go from RUN to DRAIN on key_load.
REQ-019 SHALL go from DRAIN to KEY_EXP in the first cycle with inflight==0.
REQ-020 SHALL, in DRAIN, hold s_ready=0 and continue to deliver results into the FIFO.
REQ-021 SHALL drive s_ready = (state==RUN) && (outstanding < FIFO_DEPTH) && !key_load.
REQ-022 SHALL drive core_in and core_enable from registers: one cycle after each accept, core_enable=1 and core_in=the accepted s_data; otherwise core_enable=0 and core_in=0.
REQ-023 SHALL keep an "outstanding" counter: +1 per accept, −1 per m_valid&&m_ready, unchanged when both occur in the same cycle.
REQ-024 SHALL keep an "inflight" counter: +1 per accept, −1 per core_valid_out, unchanged when both occur in the same cycle.
REQ-025 SHALL size both counters to $clog2(FIFO_DEPTH)+1 bits, and SHALL never let either wrap.
REQ-026 SHALL push core_out into the FIFO on core_valid_out.
REQ-027 SHALL drive m_valid = FIFO not empty and m_data = FIFO head in first-word-fall-through order.
REQ-028 SHALL pop one FIFO entry per m_valid&&m_ready cycle.
REQ-029 SHALL support a push and a pop in the same cycle at any occupancy, including full and empty.
REQ-030 SHALL, when core_valid_out=1 and the FIFO is full without a simultaneous pop, drop the data and set err_ovf until reset.
REQ-031 SHALL sustain one accept per cycle in RUN while the output side drains at one pop per cycle.
REQ-032 SHALL ignore core_valid_out while in IDLE or KEY_EXP, and SHALL set err_ovf if core_valid_out is seen in those states.

Reset
REQ-033 SHALL, while rst=0, force state=IDLE, both counters=0, key register=0, FIFO empty, err_ovf=0, and all outputs to 0 (key_busy=1).
REQ-034 SHALL discard all in-flight and buffered blocks on a reset asserted mid-operation, and SHALL emit no m_valid until after a new key expansion.

Structure
REQ-035 SHALL take the state encoding, AES_BLOCK_W=128 and AES_KEY_W=128 from a shared package aes_pkg.
REQ-036 SHALL implement the output buffer as one sub-module, aes_sync_fifo (parameterised width/depth, asynchronous active-low reset).

Verification
REQ-037 SHALL verify key expansion: key=000102030405060708090A0B0C0D0E0F with a key_load pulse -> exactly one core_fsm_en pulse, and key_busy falls exactly 12 cycles after the pulse.
REQ-038 SHALL verify decryption: s_data=69C4E0D86A7B0430D8CDB78070B4C55A -> m_data=00112233445566778899AABBCCDDEEFF, with m_valid for one handshake.
REQ-039 SHALL verify backpressure: 20 back-to-back blocks with m_ready=0 -> s_ready falls after 16 accepts, err_ovf stays 0, and m_ready=1 yields all 16 in order.
REQ-040 SHALL verify mid-stream rekey: key_load after 5 accepts -> no accept until those 5 results have arrived, then a single core_fsm_en pulse, then traffic resumes.
REQ-041 SHALL verify the counters under simultaneous traffic: accept and pop in the same cycle at outstanding=16 and at outstanding=0 -> counter unchanged and no data lost or duplicated.
REQ-042 SHALL verify reset mid-operation: rst=0 with 3 blocks in flight -> all outputs 0 and key_busy=1, with no stale m_valid after rst=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and the scheduler state encoding.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEY_EXP = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/aes_dec_sched_if.sv
// One valid/ready block stream; master is the producer, slave the consumer.
interface aes_dec_sched_if;
    import aes_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [AES_BLOCK_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/aes_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty.
module aes_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is legal alongside it.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/aes_dec_sched.sv
// Key/block scheduler around an AES decryption core: key expansion sequencing,
// credit-limited block issue and a FWFT result buffer.
module aes_dec_sched
    import aes_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int KEYEXP_CYCLES = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AES_KEY_W-1:0]   key,
    input  logic                   key_load,
    output logic                   key_busy,
    aes_dec_sched_if.slave         s,
    aes_dec_sched_if.master        m,
    output logic [AES_BLOCK_W-1:0] core_in,
    output logic [AES_KEY_W-1:0]   core_key,
    output logic                   core_enable,
    output logic                   core_fsm_en,
    input  logic [AES_BLOCK_W-1:0] core_out,
    input  logic                   core_valid_out,
    output logic                   err_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int KW = $clog2(KEYEXP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);
    localparam logic [KW-1:0] KX_LAST = KW'(KEYEXP_CYCLES);

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic                 kx_start;
    logic [KW-1:0]        kx_cnt;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        inflight;
    logic [AES_KEY_W-1:0] key_q;
    logic                 accept;
    logic                 pop;
    logic                 results_open;
    logic                 core_ok;
    logic                 fifo_empty;
    logic                 fifo_full;

    assign key_busy     = (state != RUN);
    assign s.ready      = (state == RUN) && (outstanding < CNT_MAX) && !key_load;
    assign accept       = s.valid && s.ready;
    assign pop          = m.valid && m.ready;
    assign results_open = (state == RUN) || (state == DRAIN);
    assign core_ok      = core_valid_out && results_open;
    assign m.valid      = !fifo_empty;
    assign core_key     = key_q;

    always_comb begin
        state_nxt = state;
        kx_start  = 1'b0;
        case (state)
            IDLE: begin
                if (key_load) begin
                    state_nxt = KEY_EXP;
                    kx_start  = 1'b1;
                end
            end
            KEY_EXP: begin
                if (key_load)               kx_start  = 1'b1;
                else if (kx_cnt == KX_LAST) state_nxt = RUN;
            end
            RUN: begin
                if (key_load) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = KEY_EXP;
                    kx_start  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The pulse cycle is KEY_EXP cycle 0; KEYEXP_CYCLES further cycles follow before RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            kx_cnt      <= '0;
            core_fsm_en <= 1'b0;
            key_q       <= '0;
        end else begin
            state       <= state_nxt;
            core_fsm_en <= kx_start;
            if (kx_start)                               kx_cnt <= '0;
            else if (state == KEY_EXP && kx_cnt != KX_LAST) kx_cnt <= kx_cnt + KW'(1);
            if (key_load) key_q <= key;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            inflight    <= '0;
            core_enable <= 1'b0;
            core_in     <= '0;
            err_ovf     <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   if (outstanding != CNT_MAX) outstanding <= outstanding + CW'(1);
                2'b01:   if (outstanding != '0)      outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            case ({accept, core_ok})
                2'b10:   if (inflight != CNT_MAX) inflight <= inflight + CW'(1);
                2'b01:   if (inflight != '0)      inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
            core_enable <= accept;
            core_in     <= accept ? s.data : '0;
            if ((core_ok && fifo_full && !pop) || (core_valid_out && !results_open)) begin
                err_ovf <= 1'b1;
            end
        end
    end

    aes_sync_fifo #(
        .WIDTH (AES_BLOCK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (core_ok),
        .push_data (core_out),
        .pop       (pop),
        .pop_data  (m.data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_aes_dec_sched.sv
// Scoreboard bench for aes_dec_sched with a fixed-latency behavioural AES core model.
module tb_aes_dec_sched;
    import aes_pkg::*;

    localparam int DEPTH    = 16;
    localparam int CORE_LAT = 4;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KAT_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] key;
    logic         key_load;
    logic         key_busy;
    logic [127:0] core_in;
    logic [127:0] core_key;
    logic         core_enable;
    logic         core_fsm_en;
    logic [127:0] core_out;
    logic         core_valid_out;
    logic         err_ovf;

    logic [127:0] cur_key;
    logic [127:0] exp_q [$];
    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    int           n_acc   = 0;
    int           n_ret   = 0;
    int           n_pop   = 0;

    always #5 clk = ~clk;

    aes_dec_sched_if s_if ();
    aes_dec_sched_if m_if ();

    aes_dec_sched #(
        .FIFO_DEPTH    (DEPTH),
        .KEYEXP_CYCLES (11)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key            (key),
        .key_load       (key_load),
        .key_busy       (key_busy),
        .s              (s_if),
        .m              (m_if),
        .core_in        (core_in),
        .core_key       (core_key),
        .core_enable    (core_enable),
        .core_fsm_en    (core_fsm_en),
        .core_out       (core_out),
        .core_valid_out (core_valid_out),
        .err_ovf        (err_ovf)
    );

    // Stand-in for AES decryption: exact for the FIPS-197 vector, a keyed bijection otherwise.
    function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [127:0] k);
        if (ct == KAT_CT && k == KAT_KEY) return KAT_PT;
        return ct ^ {k[63:0], k[127:64]} ^ 128'h5A5A_0F0F_C3C3_9696_A5A5_F0F0_3C3C_6969;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] pipe_d [CORE_LAT];
    logic         pipe_v [CORE_LAT];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CORE_LAT; i++) begin
                pipe_d[i] <= '0;
                pipe_v[i] <= 1'b0;
            end
        end else begin
            pipe_v[0] <= core_enable;
            pipe_d[0] <= ref_dec(core_in, core_key);
            for (int i = 1; i < CORE_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign core_valid_out = pipe_v[CORE_LAT-1];
    assign core_out       = pipe_d[CORE_LAT-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            n_acc = 0;
            n_ret = 0;
        end else begin
            if (core_valid_out) n_ret++;
            if (key_busy || key_load) check("s_ready_blocked", s_if.ready, 1'b0);
            else                      check("s_ready_credit", s_if.ready, exp_q.size() < DEPTH);
            if (s_if.valid && s_if.ready) begin
                exp_q.push_back(ref_dec(s_if.data, cur_key));
                n_acc++;
            end
            if (m_if.valid && m_if.ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL m_unexpected: got %h expected no output", m_if.data);
                end else begin
                    check("m_data", m_if.data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key      = k;
        key_load = 1'b1;
        cur_key  = k;
        tick();
        key_load = 1'b0;
    endtask

    task automatic wait_keyexp();
        int pulses = 0;
        int t0     = -1;
        int lat    = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (core_fsm_en) begin
                pulses++;
                t0 = i;
                check("drained_at_pulse", n_ret, n_acc);
            end
            if (!key_busy) begin
                lat = i - t0;
                break;
            end
        end
        check("fsm_en_pulses", pulses, 1);
        check("busy_fall_latency", lat, 12);
        check("core_key", core_key, cur_key);
        tick();
    endtask

    task automatic send_blocks(input int n, input int max_cycles, output int acc);
        acc = 0;
        s_if.data = rnd128();
        for (int c = 0; c < max_cycles && acc < n; c++) begin
            s_if.valid = 1'b1;
            @(negedge clk);
            if (s_if.ready) begin
                acc++;
                tick();
                s_if.data = rnd128();
            end else begin
                tick();
            end
        end
        s_if.valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        check({name, "_m_valid"}, m_if.valid, 1'b0);
        tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_key_busy", key_busy, 1'b1);
        check("rst_s_ready", s_if.ready, 1'b0);
        check("rst_m_valid", m_if.valid, 1'b0);
        check("rst_m_data", m_if.data, '0);
        check("rst_core_in", core_in, '0);
        check("rst_core_key", core_key, '0);
        check("rst_core_enable", core_enable, 1'b0);
        check("rst_core_fsm_en", core_fsm_en, 1'b0);
        check("rst_err_ovf", err_ovf, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        int acc;
        int pops0;
        int stale;
        key        = '0;
        key_load   = 1'b0;
        cur_key    = '0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        tick();
        rst = 1'b1;
        tick();

        // Key expansion with the FIPS-197 key, then the known-answer block.
        load_key(KAT_KEY);
        wait_keyexp();
        m_if.ready = 1'b1;
        pops0 = n_pop;
        s_if.data  = KAT_CT;
        s_if.valid = 1'b1;
        for (int i = 0; i < 20 && !s_if.ready; i++) tick();
        tick();
        s_if.valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_if.valid) break;
        end
        check("kat_plaintext", m_if.data, KAT_PT);
        repeat (10) tick();
        check("kat_single_handshake", n_pop - pops0, 1);

        // Backpressure: FIFO fills to 16, then pops and accepts overlap near full.
        m_if.ready = 1'b0;
        send_blocks(20, 40, acc);
        check("bp_accepts", acc, 16);
        @(negedge clk);
        check("bp_s_ready_low", s_if.ready, 1'b0);
        check("bp_m_valid", m_if.valid, 1'b1);
        check("bp_err_ovf", err_ovf, 1'b0);
        tick();
        pops0 = n_pop;
        m_if.ready = 1'b1;
        send_blocks(20, 40, acc);
        check("full_overlap_accepts", acc, 20);
        wait_empty("bp");
        check("bp_pops", n_pop - pops0, 36);

        // From empty: one accept per cycle while the output drains every cycle.
        send_blocks(32, 32, acc);
        check("throughput_accepts", acc, 32);
        wait_empty("tput");

        // Mid-stream rekey with s_valid held high throughout.
        send_blocks(5, 10, acc);
        check("rekey_pre_accepts", acc, 5);
        s_if.data  = rnd128();
        s_if.valid = 1'b1;
        load_key(rnd128());
        wait_keyexp();
        s_if.valid = 1'b0;
        send_blocks(10, 20, acc);
        check("rekey_resume_accepts", acc, 10);
        wait_empty("rekey");

        // Randomised valid/ready traffic.
        s_if.data = rnd128();
        for (int c = 0; c < 300; c++) begin
            s_if.valid = ($urandom_range(0, 3) != 0);
            m_if.ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (s_if.valid && s_if.ready) begin
                tick();
                s_if.data = rnd128();
            end else begin
                tick();
            end
        end
        s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        wait_empty("random");

        // Reset with three blocks still inside the core.
        m_if.ready = 1'b0;
        send_blocks(3, 3, acc);
        check("rst_pre_accepts", acc, 3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        tick();
        tick();
        rst = 1'b1;
        m_if.ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_if.valid || !key_busy) stale++;
        end
        check("post_rst_stale", stale, 0);
        tick();
        load_key(rnd128());
        wait_keyexp();
        send_blocks(8, 20, acc);
        check("post_rst_accepts", acc, 8);
        wait_empty("post_rst");
        check("final_err_ovf", err_ovf, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
